bank_fifo_reader: RTL and testbench
===================================

BANK_FIFO_READER -- requirements
Module: bank_fifo_reader

Interface
REQ-001 Parameter W, default 16, FIFO word width in bits.
REQ-002 Parameter N, default 8, FIFO depth exponent; one bank = 2^(N-1) words (128 at default).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  in  1  sole clock; it is the FIFO read-domain clock.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 cmd_trigger  in  1  one-cycle start request; sampled only when cmd_ready=1.
REQ-007 cmd_bankCount  in  16  number of whole banks to drain; sampled with cmd_trigger.
REQ-008 cmd_abort  in  1  terminate transfer.
REQ-009 cmd_ready  out  1  high in IDLE only.
REQ-010 done  out  1  one-cycle pulse when the transfer completes.
REQ-011 err  out  1  sticky alignment error; cleared by an accepted cmd_trigger or by rst.
REQ-012 fifo_trigger  out  1  connects to the FIFO read-trigger input.
REQ-013 fifo_data  in  W  FIFO read data; combinational for the current read address.
REQ-014 fifo_ok  in  1  FIFO read-ok.
REQ-015 fifo_bank  in  1  FIFO read-bank bit.
REQ-016 out_valid / out_data[W] / out_last  out  downstream stream; out_last marks the final word of each bank.
REQ-017 out_ready  in  1  downstream accept.

Function
REQ-018 States SHALL be IDLE, WAIT, DRAIN, FLUSH.
- IDLE: on cmd_trigger with cmd_bankCount>0, go to WAIT.
- IDLE: on cmd_trigger with cmd_bankCount=0, pulse done the next cycle, stay in IDLE, and issue no fifo_trigger.
REQ-019 WAIT (bank start):
- When fifo_ok=1, compare fifo_bank with the expected-bank register.
- On mismatch, set err; the transfer continues regardless.
- Go to DRAIN.
REQ-020 The expected-bank register SHALL load fifo_bank at the first WAIT of a command and toggle at every completed bank.
REQ-021 fifo_trigger SHALL be asserted, combinationally, exactly when state=DRAIN && fifo_ok && (!out_valid || out_ready).
REQ-022 On a cycle with fifo_trigger=1:
- fifo_data is registered into out_data.
- out_valid is set at the next edge, giving 1-cycle latency from trigger to out_valid.
- The word counter (N-1 bits) increments.
REQ-023 out_valid SHALL clear on out_ready && !fifo_trigger.
- out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-024 When fifo_ok=0 in DRAIN, reads SHALL stall without error; throughput is one word per clk while fifo_ok && out_ready.
REQ-025 The trigger of word 2^(N-1)-1 SHALL register out_last=1 and decrement the bank counter.
- Word counter wraps to 0.
- Next state is WAIT if banks remain, otherwise FLUSH.
REQ-026 FLUSH: when out_valid && out_ready (last word accepted), pulse done and go to IDLE.
REQ-027 cmd_abort, in any state, SHALL at the next edge:
- go to IDLE;
- clear out_valid and out_last;
- issue no further fifo_trigger, including in the abort cycle itself.
- Words not yet accepted are discarded and done is not pulsed.
REQ-028 If cmd_abort and cmd_trigger are asserted together, abort SHALL win.
- cmd_trigger while not IDLE SHALL be ignored.
REQ-029 Counters SHALL never wrap below 0; bankCount 0xFFFF SHALL be supported.

Reset
REQ-030 rst SHALL force:
- state IDLE;
- cmd_ready=1;
- out_valid=0, out_last=0, out_data=0;
- done=0, err=0, fifo_trigger=0;
- all counters 0.
REQ-031 rst mid-transfer SHALL behave like cmd_abort and additionally clear err.

Structure
REQ-032 Package bank_fifo_pkg SHALL hold the default W/N constants and the state enumeration.
REQ-033 The output register (data/valid/last with hold-on-stall) SHALL be a sub-module named stream_reg.

Verification
REQ-034 Happy path: W=16, N=8, bankCount=2, FIFO prefilled with 0..255, out_ready=1 -> 256 words 0..255 in order.
- out_last on words 127 and 255.
- done exactly one cycle after word 255 is accepted; err=0.
REQ-035 Backpressure: out_ready toggles 1/0 every cycle -> no loss or duplication; out_data stable while stalled; 127 cycles minimum spacing per 64 words.
REQ-036 Starved FIFO: fifo_ok=0 for 10 cycles at bank start and 5 cycles mid-bank -> fifo_trigger=0 throughout both gaps; err=0; ordering intact.
REQ-037 Zero count: cmd_bankCount=0 -> done one cycle later; fifo_trigger never asserted.
REQ-038 Abort: cmd_abort at word 40 of bank 0 -> IDLE and out_valid=0 next cycle; done=0; a new cmd_trigger is accepted immediately after.
REQ-039 Misalignment: fifo_bank held at the same value across the start of 2 consecutive banks -> err=1 at the second WAIT; err stays 1 until the next cmd_trigger.

Source files
------------

// File: rtl/bank_fifo_pkg.sv
// Shared defaults and FSM encoding for the banked FIFO reader.
package bank_fifo_pkg;

    localparam int W_DEF = 16;
    localparam int N_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_t;

endpackage

// File: rtl/bank_fifo_reader_stream_reg.sv
// Single-entry output register: loads on a FIFO read, holds while the consumer stalls.
module stream_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_last,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_last
);

    logic         r_valid;
    logic         r_last;
    logic [W-1:0] r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
            r_last  <= i_last;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_last  = r_last;

endmodule

// File: rtl/bank_fifo_reader.sv
// Drains a whole number of FIFO banks into a valid/ready stream, checking the
// FIFO bank bit against the expected ping-pong sequence at every bank start.
module bank_fifo_reader
    import bank_fifo_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_trigger,
    input  logic [15:0]  cmd_bankCount,
    input  logic         cmd_abort,
    output logic         cmd_ready,
    output logic         done,
    output logic         err,
    output logic         fifo_trigger,
    input  logic [W-1:0] fifo_data,
    input  logic         fifo_ok,
    input  logic         fifo_bank,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         out_last,
    input  logic         out_ready
);

    localparam int CW = N - 1;
    localparam logic [CW-1:0] LAST_IDX = '1;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [15:0]   r_bank_cnt;
    logic [CW-1:0] r_word_cnt;
    logic          r_exp_bank;
    logic          r_first;
    logic          r_err;
    logic          r_done;

    logic          w_trig;
    logic          w_last_word;
    logic          w_accept;
    logic          w_bank_start;
    logic          w_zero_done;
    logic          w_flush_done;
    logic          w_out_valid;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_trig       = 1'b0;
        w_accept     = 1'b0;
        w_bank_start = 1'b0;
        w_zero_done  = 1'b0;
        w_flush_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_trigger) begin
                    w_accept = 1'b1;
                    if (cmd_bankCount != 16'd0) w_state_nxt = WAIT;
                    else                        w_zero_done = 1'b1;
                end
            end
            WAIT: begin
                if (fifo_ok) begin
                    w_bank_start = 1'b1;
                    w_state_nxt  = DRAIN;
                end
            end
            DRAIN: begin
                if (fifo_ok && (!w_out_valid || out_ready)) begin
                    w_trig = 1'b1;
                    if (r_word_cnt == LAST_IDX)
                        w_state_nxt = (r_bank_cnt > 16'd1) ? WAIT : FLUSH;
                end
            end
            FLUSH: begin
                if (w_out_valid && out_ready) begin
                    w_flush_done = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Abort (and reset) must suppress the read strobe in the very same cycle.
        if (cmd_abort || rst) begin
            w_state_nxt  = IDLE;
            w_trig       = 1'b0;
            w_accept     = 1'b0;
            w_bank_start = 1'b0;
            w_zero_done  = 1'b0;
            w_flush_done = 1'b0;
        end
    end

    assign w_last_word = w_trig && (r_word_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bank_cnt <= '0;
            r_word_cnt <= '0;
            r_exp_bank <= 1'b0;
            r_first    <= 1'b0;
            r_err      <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_zero_done || w_flush_done;
            if (cmd_abort) begin
                r_bank_cnt <= '0;
                r_word_cnt <= '0;
                r_first    <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_err      <= 1'b0;
                    r_bank_cnt <= cmd_bankCount;
                    r_word_cnt <= '0;
                    r_first    <= 1'b1;
                end
                // First bank of a command defines the phase; later banks must alternate.
                if (w_bank_start) begin
                    r_first <= 1'b0;
                    if (r_first)                      r_exp_bank <= fifo_bank;
                    else if (fifo_bank != r_exp_bank) r_err      <= 1'b1;
                end
                if (w_trig) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                    if (w_last_word) begin
                        r_exp_bank <= ~r_exp_bank;
                        if (r_bank_cnt != 16'd0) r_bank_cnt <= r_bank_cnt - 16'd1;
                    end
                end
            end
        end
    end

    stream_reg #(.W(W)) u_stream_reg (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (cmd_abort),
        .i_load  (w_trig),
        .i_data  (fifo_data),
        .i_last  (w_last_word),
        .i_ready (out_ready),
        .o_valid (w_out_valid),
        .o_data  (out_data),
        .o_last  (out_last)
    );

    assign out_valid    = w_out_valid;
    assign fifo_trigger = w_trig;
    assign cmd_ready    = (r_state == IDLE);
    assign done         = r_done;
    assign err          = r_err;

endmodule

// File: tb/tb_bank_fifo_reader.sv
// Bench for bank_fifo_reader: FIFO model plus a word-order scoreboard built from the bank rules.
module tb_bank_fifo_reader;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int BW = 128;

    logic         clk = 1'b0;
    logic         rst, cmd_trigger, cmd_abort, cmd_ready, done, err;
    logic         fifo_trigger, fifo_ok, fifo_bank, out_valid, out_last, out_ready;
    logic [15:0]  cmd_bankCount;
    logic [W-1:0] fifo_data, out_data;

    always #5 clk = ~clk;

    // FIFO model: circular memory, read pointer steps on every read strobe.
    logic [W-1:0] mem [0:1023];
    logic [9:0]   rd_ptr;
    logic         force_en = 1'b0, force_val = 1'b0;

    assign fifo_data = mem[rd_ptr];
    assign fifo_bank = force_en ? force_val : rd_ptr[7];

    always @(posedge clk) begin
        if (rst)               rd_ptr <= '0;
        else if (fifo_trigger) rd_ptr <= rd_ptr + 10'd1;
    end

    bank_fifo_reader #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst), .cmd_trigger(cmd_trigger), .cmd_bankCount(cmd_bankCount),
        .cmd_abort(cmd_abort), .cmd_ready(cmd_ready), .done(done), .err(err),
        .fifo_trigger(fifo_trigger), .fifo_data(fifo_data), .fifo_ok(fifo_ok),
        .fifo_bank(fifo_bank), .out_valid(out_valid), .out_data(out_data),
        .out_last(out_last), .out_ready(out_ready)
    );

    typedef struct packed { logic [W-1:0] d; logic l; } exp_t;
    typedef struct { int banks; int rmode; int omode; bit mis; bit exp_err; } vec_t;

    exp_t         q[$];
    vec_t         vt[6];
    int           tests = 0, fails = 0;
    int           cyc = 0, acc_n = 0, acc0 = 0, acc63 = 0, last_acc = 0;
    int           done_n = 0, done_cyc = 0, gap_trig = 0, trig_n = 0;
    bit           gap = 1'b0;
    logic         prev_valid = 1'b0, prev_ready = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic score();
        exp_t e;
        cyc++;
        if (out_valid && prev_valid && !prev_ready) chk("hold_data", int'(out_data), int'(prev_data));
        if (gap && fifo_trigger) gap_trig++;
        if (fifo_trigger) trig_n++;
        if (out_valid && out_ready) begin
            if (q.size() == 0) chk("extra_word", 1, 0);
            else begin
                e = q.pop_front();
                chk("word_data", int'(out_data), int'(e.d));
                chk("word_last", int'(out_last), int'(e.l));
            end
            if (acc_n == 0)  acc0 = cyc;
            if (acc_n == 63) acc63 = cyc;
            if (acc_n == 64) chk("err_bank0", int'(err), 0);
            acc_n++;
            last_acc = cyc;
        end
        if (done) begin done_n++; done_cyc = cyc; end
        prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
    endtask

    task tick();
        @(negedge clk);
        score();
        @(posedge clk);
        #1;
    endtask

    // Expected stream: the next banks*128 FIFO words in order, last on every 128th.
    task automatic load_q(int banks);
        logic [9:0] idx;
        exp_t       e;
        q.delete();
        acc_n = 0; done_n = 0; gap_trig = 0;
        for (int i = 0; i < banks * BW; i++) begin
            idx = rd_ptr + 10'(i);
            e.d = mem[idx];
            e.l = ((i % BW) == BW - 1);
            q.push_back(e);
        end
    endtask

    task automatic run_vec(vec_t v);
        logic [9:0] sp, dw;
        int         gap2;
        load_q(v.banks);
        sp = rd_ptr;
        force_val = rd_ptr[7];
        force_en  = v.mis;
        chk("ready_before", int'(cmd_ready), 1);
        cmd_bankCount = 16'(v.banks); cmd_trigger = 1'b1; out_ready = 1'b1; fifo_ok = 1'b1;
        tick();
        cmd_trigger = 1'b0;
        gap2 = 0;
        for (int k = 0; k < 6000 && done_n == 0; k++) begin
            case (v.rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = (k % 2 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            dw = rd_ptr - sp;
            case (v.omode)
                0: fifo_ok = 1'b1;
                1: begin
                    if (k < 10) fifo_ok = 1'b0;
                    else if (dw >= 10'd50 && gap2 < 5) begin fifo_ok = 1'b0; gap2++; end
                    else fifo_ok = 1'b1;
                end
                default: fifo_ok = ($urandom_range(0, 3) != 0);
            endcase
            gap = (v.omode == 1) && !fifo_ok;
            tick();
            if (k == 0) chk("err_clr_on_trig", int'(err), 0);
        end
        gap = 1'b0;
        if (done_n == 0) begin
            chk("timeout", 0, 1);
            cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
        end
        out_ready = 1'b1; fifo_ok = 1'b1;
        tick(); tick();
        chk("words_left", q.size(), 0);
        chk("word_count", acc_n, v.banks * BW);
        chk("done_pulses", done_n, 1);
        chk("done_timing", done_cyc - last_acc, 1);
        chk("err_final", int'(err), int'(v.exp_err));
        chk("gap_trig", gap_trig, 0);
        chk("idle_after", int'(cmd_ready), 1);
        if (v.rmode == 1) chk("bp_spacing", int'(acc63 - acc0 >= 126), 1);
        force_en = 1'b0;
    endtask

    initial begin
        int   t0, tc, d0;
        vec_t rv;
        for (int i = 0; i < 1024; i++) mem[i] = (i < 256) ? W'(i) : W'($urandom);
        vt[0] = '{2, 0, 0, 1'b0, 1'b0};
        vt[1] = '{1, 1, 0, 1'b0, 1'b0};
        vt[2] = '{2, 0, 1, 1'b0, 1'b0};
        vt[3] = '{2, 0, 0, 1'b1, 1'b1};
        vt[4] = '{3, 2, 2, 1'b0, 1'b0};
        vt[5] = '{2, 2, 0, 1'b1, 1'b1};

        rst = 1'b1; cmd_trigger = 1'b0; cmd_abort = 1'b0; cmd_bankCount = '0;
        fifo_ok = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        repeat (3) tick();
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_last",  int'(out_last), 0);
        chk("rst_data",  int'(out_data), 0);
        chk("rst_done",  int'(done), 0);
        chk("rst_err",   int'(err), 0);
        chk("rst_trig",  int'(fifo_trigger), 0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", int'(cmd_ready), 1);

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        chk("err_sticky_idle", int'(err), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rst_clears_err", int'(err), 0);
        chk("rst_clears_data", int'(out_data), 0);
        tick();

        // Zero bank count: immediate done, no FIFO reads.
        t0 = trig_n; done_n = 0;
        cmd_bankCount = 16'd0; cmd_trigger = 1'b1;
        tick(); tc = cyc; cmd_trigger = 1'b0;
        repeat (4) tick();
        chk("zero_done_cnt", done_n, 1);
        chk("zero_done_time", done_cyc - tc, 1);
        chk("zero_no_trig", trig_n - t0, 0);
        chk("zero_ready", int'(cmd_ready), 1);

        // Abort at word 40 of bank 0, with a simultaneous trigger that must be ignored.
        load_q(2);
        cmd_bankCount = 16'd2; cmd_trigger = 1'b1; out_ready = 1'b1; fifo_ok = 1'b1;
        tick(); cmd_trigger = 1'b0;
        for (int k = 0; k < 2000 && acc_n < 40; k++) tick();
        chk("abort_reached", acc_n, 40);
        d0 = done_n; t0 = trig_n;
        cmd_abort = 1'b1; cmd_trigger = 1'b1;
        tick();
        cmd_abort = 1'b0; cmd_trigger = 1'b0;
        chk("abort_trig", trig_n - t0, 0);
        chk("abort_idle", int'(cmd_ready), 1);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_last", int'(out_last), 0);
        q.delete();
        tick();
        chk("abort_no_done", done_n - d0, 0);
        t0 = trig_n;
        cmd_abort = 1'b1; cmd_trigger = 1'b1; cmd_bankCount = 16'd1;
        tick();
        cmd_abort = 1'b0; cmd_trigger = 1'b0;
        chk("abort_wins_ready", int'(cmd_ready), 1);
        tick();
        chk("abort_wins_no_trig", trig_n - t0, 0);
        run_vec('{1, 0, 0, 1'b0, 1'b0});

        // Reset in the middle of a drain behaves like abort.
        load_q(1);
        cmd_bankCount = 16'd1; cmd_trigger = 1'b1;
        tick(); cmd_trigger = 1'b0;
        repeat (20) tick();
        t0 = trig_n;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst_trig", trig_n - t0, 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_valid", int'(out_valid), 0);
        q.delete();
        tick();

        for (int r = 0; r < 4; r++) begin
            rv.banks   = $urandom_range(1, 2);
            rv.rmode   = $urandom_range(0, 2);
            rv.omode   = $urandom_range(0, 1) * 2;
            rv.mis     = 1'b0;
            rv.exp_err = 1'b0;
            run_vec(rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
